// File: rtl/ff_bank.sv
// ff_bank: WIDTH-bit bank of mode-selectable SR/JK/D/T flip-flops with forbidden-input tracking.
module ff_bank #(
  parameter int WIDTH = 8,
  parameter int SR_POLICY = 0,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             illegal,
  output logic [WIDTH-1:0] illegal_mask,
  output logic [CNT_W-1:0] illegal_cnt
);
  typedef enum logic [1:0] {SR = 2'b00, JK = 2'b01, D = 2'b10, T = 2'b11} mode_t;
  logic [WIDTH-1:0] ill_now, sr_res, sr_nxt, jk_nxt, nxt;
  logic any_ill;
  // Value a forbidden SR bit resolves to; hold keeps the current q.
  assign sr_res = SR_POLICY == 1 ? {WIDTH{1'b1}} : SR_POLICY == 2 ? {WIDTH{1'b0}} : q;
  assign sr_nxt = (a & ~b) | (q & ~a & ~b) | (a & b & sr_res);
  assign jk_nxt = (a & ~q) | (~b & q);
  assign nxt = mode_t'(mode) == SR ? sr_nxt : mode_t'(mode) == JK ? jk_nxt :
               mode_t'(mode) == D ? a : q ^ a;
  assign ill_now = (en && mode_t'(mode) == SR) ? (a & b) : {WIDTH{1'b0}};
  assign any_ill = |ill_now;
  assign qbar = ~q;
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VAL;
      illegal <= 1'b0;
      illegal_mask <= {WIDTH{1'b0}};
      illegal_cnt <= {CNT_W{1'b0}};
    end else begin
      if (en) q <= nxt;
      illegal <= any_ill;
      if (clr_err) begin
        illegal_mask <= ill_now;
        illegal_cnt <= {{(CNT_W-1){1'b0}}, any_ill};
      end else begin
        illegal_mask <= illegal_mask | ill_now;
        if (any_ill && !(&illegal_cnt)) illegal_cnt <= illegal_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_ff_bank.sv
// tb_ff_bank: directed vector table against three policy variants of ff_bank.
module tb_ff_bank;
  logic clk = 1'b0, rst, en, clr_err;
  logic [1:0] mode;
  logic [7:0] a, b;
  logic [7:0] q0, q1, q2, qb0, qb1, qb2, m0, m1, m2;
  logic il0, il1, il2;
  logic [3:0] c0, c1, c2;
  int n_vec = 0, n_bad = 0;

  always #5 clk = ~clk;

  ff_bank #(.WIDTH(8), .SR_POLICY(0), .RST_VAL(8'hA5), .CNT_W(4)) u0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .clr_err(clr_err),
    .q(q0), .qbar(qb0), .illegal(il0), .illegal_mask(m0), .illegal_cnt(c0));
  ff_bank #(.WIDTH(8), .SR_POLICY(1), .RST_VAL(8'hA5), .CNT_W(4)) u1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .clr_err(clr_err),
    .q(q1), .qbar(qb1), .illegal(il1), .illegal_mask(m1), .illegal_cnt(c1));
  ff_bank #(.WIDTH(8), .SR_POLICY(2), .RST_VAL(8'hA5), .CNT_W(4)) u2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .clr_err(clr_err),
    .q(q2), .qbar(qb2), .illegal(il2), .illegal_mask(m2), .illegal_cnt(c2));

  typedef struct {
    logic rst, en;
    logic [1:0] mode;
    logic [7:0] a, b;
    logic clr;
    logic [7:0] eq0, eq1, eq2;
    logic ill;
    logic [7:0] mask;
    logic [3:0] cnt;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL vec %0d %s: got %h expected %h", idx, name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic e, input logic [1:0] md, input logic [7:0] va,
                     input logic [7:0] vb, input logic cl, input logic [7:0] x0, input logic [7:0] x1,
                     input logic [7:0] x2, input logic il, input logic [7:0] mk, input logic [3:0] ct);
    vec_t v;
    v.rst = r; v.en = e; v.mode = md; v.a = va; v.b = vb; v.clr = cl;
    v.eq0 = x0; v.eq1 = x1; v.eq2 = x2; v.ill = il; v.mask = mk; v.cnt = ct;
    tbl.push_back(v);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'b00; a = '0; b = '0; clr_err = 1'b0;
    //   rst en  mode   a      b      clr  q0     q1     q2     ill  mask   cnt
    add(1, 1, 2'b00, 8'hFF, 8'hFF, 0, 8'hA5, 8'hA5, 8'hA5, 0, 8'h00, 4'd0);
    add(1, 0, 2'b11, 8'h3C, 8'h12, 1, 8'hA5, 8'hA5, 8'hA5, 0, 8'h00, 4'd0);
    add(0, 1, 2'b10, 8'h3C, 8'h00, 0, 8'h3C, 8'h3C, 8'h3C, 0, 8'h00, 4'd0);
    add(0, 1, 2'b11, 8'hFF, 8'h00, 0, 8'hC3, 8'hC3, 8'hC3, 0, 8'h00, 4'd0);
    add(0, 1, 2'b11, 8'hFF, 8'h00, 0, 8'h3C, 8'h3C, 8'h3C, 0, 8'h00, 4'd0);
    add(0, 0, 2'b10, 8'h0F, 8'h00, 0, 8'h3C, 8'h3C, 8'h3C, 0, 8'h00, 4'd0);
    add(0, 1, 2'b10, 8'hF0, 8'h00, 0, 8'hF0, 8'hF0, 8'hF0, 0, 8'h00, 4'd0);
    add(0, 1, 2'b00, 8'h0F, 8'hFF, 0, 8'h00, 8'h0F, 8'h00, 1, 8'h0F, 4'd1);
    add(0, 1, 2'b00, 8'h00, 8'h00, 0, 8'h00, 8'h0F, 8'h00, 0, 8'h0F, 4'd1);
    add(0, 1, 2'b10, 8'h55, 8'h00, 0, 8'h55, 8'h55, 8'h55, 0, 8'h0F, 4'd1);
    add(0, 1, 2'b01, 8'hFF, 8'hFF, 0, 8'hAA, 8'hAA, 8'hAA, 0, 8'h0F, 4'd1);
    add(0, 1, 2'b01, 8'h0F, 8'hF0, 0, 8'h0F, 8'h0F, 8'h0F, 0, 8'h0F, 4'd1);
    add(0, 1, 2'b01, 8'h00, 8'h00, 0, 8'h0F, 8'h0F, 8'h0F, 0, 8'h0F, 4'd1);
    add(0, 1, 2'b00, 8'h30, 8'h03, 0, 8'h3C, 8'h3C, 8'h3C, 0, 8'h0F, 4'd1);
    add(0, 0, 2'b00, 8'hFF, 8'hFF, 0, 8'h3C, 8'h3C, 8'h3C, 0, 8'h0F, 4'd1);
    // 20 back-to-back forbidden cycles: illegal stays high, counter pins at 15
    for (int k = 0; k < 20; k++)
      add(0, 1, 2'b00, 8'h80, 8'h80, 0, 8'h3C, 8'hBC, 8'h3C, 1, 8'h8F, (k + 2 > 15) ? 4'd15 : 4'(k + 2));
    add(0, 1, 2'b00, 8'h01, 8'h01, 1, 8'h3C, 8'hBD, 8'h3C, 1, 8'h01, 4'd1);
    add(0, 0, 2'b00, 8'hFF, 8'hFF, 1, 8'h3C, 8'hBD, 8'h3C, 0, 8'h00, 4'd0);
    add(0, 1, 2'b00, 8'h02, 8'h02, 0, 8'h3C, 8'hBF, 8'h3C, 1, 8'h02, 4'd1);
    add(0, 1, 2'b00, 8'h02, 8'h02, 0, 8'h3C, 8'hBF, 8'h3C, 1, 8'h02, 4'd2);
    add(1, 1, 2'b00, 8'hFF, 8'hFF, 0, 8'hA5, 8'hA5, 8'hA5, 0, 8'h00, 4'd0);
    add(0, 1, 2'b10, 8'h11, 8'h00, 0, 8'h11, 8'h11, 8'h11, 0, 8'h00, 4'd0);
    add(0, 1, 2'b10, 8'h11, 8'h00, 1, 8'h11, 8'h11, 8'h11, 0, 8'h00, 4'd0);
    foreach (tbl[i]) begin
      @(negedge clk);
      rst = tbl[i].rst; en = tbl[i].en; mode = tbl[i].mode;
      a = tbl[i].a; b = tbl[i].b; clr_err = tbl[i].clr;
      @(posedge clk);
      #1;
      n_vec++;
      chk("q_pol0", i, q0, tbl[i].eq0);
      chk("q_pol1", i, q1, tbl[i].eq1);
      chk("q_pol2", i, q2, tbl[i].eq2);
      chk("qbar_pol0", i, qb0, ~tbl[i].eq0);
      chk("qbar_pol1", i, qb1, ~tbl[i].eq1);
      chk("illegal", i, {7'd0, il0}, {7'd0, tbl[i].ill});
      chk("illegal_pol1", i, {7'd0, il1}, {7'd0, tbl[i].ill});
      chk("illegal_pol2", i, {7'd0, il2}, {7'd0, tbl[i].ill});
      chk("mask_pol0", i, m0, tbl[i].mask);
      chk("mask_pol1", i, m1, tbl[i].mask);
      chk("mask_pol2", i, m2, tbl[i].mask);
      chk("cnt_pol0", i, {4'd0, c0}, {4'd0, tbl[i].cnt});
      chk("cnt_pol1", i, {4'd0, c1}, {4'd0, tbl[i].cnt});
      chk("cnt_pol2", i, {4'd0, c2}, {4'd0, tbl[i].cnt});
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
